// File: rtl/rice_split_encoder_if.sv
// Handshake bundle for the Rice split-sample encoder: block control,
// sample load channel and packed output word channel.
interface rice_split_encoder_if #(
  parameter int DW = 16
);
  logic          start;
  logic [5:0]    j;
  logic [5:0]    k;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          flush;
  logic [31:0]   word_out;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic          block_done;
  logic          err;

  modport master (
    output start, j, k, sample_in, sample_valid, flush, word_ready,
    input  sample_ready, word_out, word_valid, busy, block_done, err
  );

  modport slave (
    input  start, j, k, sample_in, sample_valid, flush, word_ready,
    output sample_ready, word_out, word_valid, busy, block_done, err
  );
endinterface

// File: rtl/rice_split_encoder.sv
// Rice split-sample encoder: buffers a block of mapped residuals, then packs
// ID, FS codes and k-bit split fields MSB-first into 32-bit words.
module rice_split_encoder #(
  parameter int DW   = 16,
  parameter int JMAX = 32,
  parameter int ID_W = 4
) (
  input logic clk1,
  input logic reset,
  rice_split_encoder_if.slave bus
);
  localparam int          AW      = $clog2(JMAX);
  localparam logic [5:0]  JMAX_L  = 6'(JMAX);
  localparam logic [5:0]  K_MAX   = 6'(DW - 2);
  localparam logic [31:0] ID_MASK = (32'd1 << ID_W) - 32'd1;

  typedef enum logic [2:0] {IDLE, LOAD, ID, FS, KB, FLUSH} state_t;

  state_t        state, state_nx;
  logic [5:0]    j_r, k_r, idx, j_nx, k_nx, idx_nx, idx_inc;
  logic [DW-1:0] q, q_nx, kb_mask;
  logic [DW-1:0] sample_buf [JMAX];
  logic [63:0]   acc, acc_nx, acc_base;
  logic [6:0]    fill, fill_nx, fill_base, app_shift;
  logic [5:0]    app_len;
  logic [31:0]   app_bits, id_bits;
  logic          hs, can_append, app_req, do_append, last, start_ok;
  logic          load_we, done_nx, err_nx;
  logic          sample_ready_r, word_valid_r, busy_r, block_done_r, err_r;
  logic [31:0]   word_out_r;

  assign hs       = word_valid_r & bus.word_ready;
  assign idx_inc  = idx + 6'd1;
  assign last     = (idx == j_r - 6'd1);
  assign start_ok = (bus.j != 6'd0) && (bus.j <= JMAX_L) && (bus.k <= K_MAX);
  assign kb_mask  = (DW'(1) << k_r) - DW'(1);
  assign id_bits  = (32'(k_r) + 32'd1) & ID_MASK;

  assign bus.sample_ready = sample_ready_r;
  assign bus.word_valid   = word_valid_r;
  assign bus.word_out     = word_out_r;
  assign bus.busy         = busy_r;
  assign bus.block_done   = block_done_r;
  assign bus.err          = err_r;

  // Next-state and packer: an append lands after the bits that remain once any
  // concurrent word handshake has been removed; otherwise the FSM stalls.
  always_comb begin
    state_nx  = state;
    j_nx      = j_r;
    k_nx      = k_r;
    idx_nx    = idx;
    q_nx      = q;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    load_we   = 1'b0;
    app_req   = 1'b0;
    app_len   = 6'd0;
    app_bits  = 32'd0;
    acc_base  = hs ? {acc[31:0], 32'd0} : acc;
    fill_base = hs ? fill - 7'd32 : fill;
    can_append = (fill_base < 7'd32);

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            j_nx     = bus.j;
            k_nx     = bus.k;
            idx_nx   = 6'd0;
            state_nx = LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end else if (bus.flush && fill != 7'd0) begin
          state_nx = FLUSH;
        end
      end
      LOAD: begin
        if (bus.sample_valid && sample_ready_r) begin
          load_we = 1'b1;
          if (last) begin
            idx_nx   = 6'd0;
            state_nx = ID;
          end else begin
            idx_nx = idx_inc;
          end
        end
      end
      ID: begin
        app_req  = 1'b1;
        app_len  = 6'(ID_W);
        app_bits = id_bits;
        if (can_append) begin
          idx_nx   = 6'd0;
          q_nx     = sample_buf[0] >> k_r;
          state_nx = FS;
        end
      end
      FS: begin
        app_req = 1'b1;
        if (q >= DW'(32)) begin
          app_len = 6'd32;
          if (can_append) q_nx = q - DW'(32);
        end else begin
          app_len  = 6'(q) + 6'd1;
          app_bits = 32'd1;
          if (can_append) begin
            if (last) begin
              idx_nx = 6'd0;
              if (k_r != 6'd0) begin
                state_nx = KB;
              end else begin
                state_nx = IDLE;
                done_nx  = 1'b1;
              end
            end else begin
              idx_nx = idx_inc;
              q_nx   = sample_buf[idx_inc[AW-1:0]] >> k_r;
            end
          end
        end
      end
      KB: begin
        app_req  = 1'b1;
        app_len  = k_r;
        app_bits = 32'(sample_buf[idx[AW-1:0]] & kb_mask);
        if (can_append) begin
          if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx_inc;
          end
        end
      end
      FLUSH: begin
        // A word left over from before the flush drains first.
        if (hs && fill <= 7'd32) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    do_append = app_req & can_append;
    app_shift = 7'd64 - fill_base - {1'b0, app_len};
    acc_nx    = acc_base;
    fill_nx   = fill_base;
    if (state == FLUSH && hs && fill <= 7'd32) begin
      acc_nx  = 64'd0;
      fill_nx = 7'd0;
    end else if (do_append) begin
      acc_nx  = acc_base | ({32'd0, app_bits} << app_shift);
      fill_nx = fill_base + {1'b0, app_len};
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state          <= IDLE;
      j_r            <= 6'd0;
      k_r            <= 6'd0;
      idx            <= 6'd0;
      q              <= '0;
      acc            <= 64'd0;
      fill           <= 7'd0;
      sample_ready_r <= 1'b0;
      word_valid_r   <= 1'b0;
      word_out_r     <= 32'd0;
      busy_r         <= 1'b0;
      block_done_r   <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state          <= state_nx;
      j_r            <= j_nx;
      k_r            <= k_nx;
      idx            <= idx_nx;
      q              <= q_nx;
      acc            <= acc_nx;
      fill           <= fill_nx;
      sample_ready_r <= (state_nx == LOAD);
      word_valid_r   <= (fill_nx >= 7'd32) || (state_nx == FLUSH);
      word_out_r     <= acc_nx[63:32];
      busy_r         <= (state_nx != IDLE);
      block_done_r   <= done_nx;
      err_r          <= err_nx;
    end
  end

  always_ff @(posedge clk1) begin
    if (load_we) sample_buf[idx[AW-1:0]] <= bus.sample_in;
  end
endmodule

// File: tb/tb_rice_split_encoder.sv
// Self-checking bench: directed and randomized blocks compared against a
// bit-queue reference model of the Rice split-sample stream.
module tb_rice_split_encoder;
  localparam int DW   = 16;
  localparam int JMAX = 32;
  localparam int ID_W = 4;

  logic clk1 = 1'b0;
  logic reset;

  rice_split_encoder_if #(.DW(DW)) bus();

  rice_split_encoder #(.DW(DW), .JMAX(JMAX), .ID_W(ID_W)) dut (
    .clk1(clk1),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  bit model_bits[$];
  logic [31:0] exp_words[$];
  logic [31:0] got_words[$];
  int smp[JMAX];
  bit bp_mode = 1'b0;
  bit hold_check = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [31:0] prev_word = 32'd0;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Collects accepted words, counts block_done pulses and checks output hold under stall.
  always @(negedge clk1) begin
    if (reset) begin
      got_words.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.block_done) done_count++;
      if (hold_check && prev_valid && !prev_ready) begin
        checkOutput("hold word_valid", 32'(bus.word_valid), 32'd1);
        checkOutput("hold word_out", bus.word_out, prev_word);
      end
      if (bus.word_valid && bus.word_ready) got_words.push_back(bus.word_out);
      prev_valid = bus.word_valid;
      prev_ready = bus.word_ready;
      prev_word  = bus.word_out;
    end
  end

  initial begin
    bus.word_ready = 1'b1;
    forever begin
      @(posedge clk1);
      #1;
      bus.word_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #600000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic void drainModel();
    logic [31:0] w;
    while (model_bits.size() >= 32) begin
      w = 32'd0;
      for (int b = 0; b < 32; b++) w = {w[30:0], model_bits.pop_front()};
      exp_words.push_back(w);
    end
  endfunction

  function automatic void modelBlock(input int jj, input int kk);
    for (int b = ID_W - 1; b >= 0; b--) model_bits.push_back(bit'(((kk + 1) >> b) & 1));
    for (int i = 0; i < jj; i++) begin
      repeat (smp[i] >> kk) model_bits.push_back(1'b0);
      model_bits.push_back(1'b1);
    end
    if (kk > 0)
      for (int i = 0; i < jj; i++)
        for (int b = kk - 1; b >= 0; b--) model_bits.push_back(bit'((smp[i] >> b) & 1));
    drainModel();
  endfunction

  function automatic void modelFlush();
    if (model_bits.size() > 0) begin
      while (model_bits.size() % 32 != 0) model_bits.push_back(1'b0);
      drainModel();
    end
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulseStart(input int jj, input int kk, input bit ok);
    bus.start = 1'b1;
    bus.j = 6'(jj);
    bus.k = 6'(kk);
    tick();
    bus.start = 1'b0;
    checkOutput($sformatf("sample_ready after start j=%0d k=%0d", jj, kk), 32'(bus.sample_ready), 32'(ok));
    checkOutput($sformatf("busy after start j=%0d k=%0d", jj, kk), 32'(bus.busy), 32'(ok));
    checkOutput($sformatf("err after start j=%0d k=%0d", jj, kk), 32'(bus.err), 32'(!ok));
  endtask

  task automatic feedSamples(input int jj, input bit gaps);
    int idx = 0;
    int budget = 0;
    bit accept;
    while (idx < jj && budget < 1000) begin
      bus.sample_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.sample_in = DW'(smp[idx]);
      @(negedge clk1);
      accept = bus.sample_valid && bus.sample_ready;
      tick();
      if (accept) idx++;
      budget++;
    end
    bus.sample_valid = 1'b0;
    if (idx < jj) checkOutput("sample load timeout", 32'(idx), 32'(jj));
  endtask

  task automatic applyStimulus(input int jj, input int kk, input bit gaps, input bit check_lat);
    int t0, t1, lat;
    bit seen = 1'b0;
    modelBlock(jj, kk);
    pulseStart(jj, kk, 1'b1);
    feedSamples(jj, gaps);
    t0 = cyc;
    t1 = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk1);
      if (bus.block_done) begin
        seen = 1'b1;
        t1 = cyc;
      end
    end
    checkOutput($sformatf("block_done j=%0d k=%0d", jj, kk), 32'(seen), 32'd1);
    if (check_lat && seen) begin
      lat = 1;
      for (int i = 0; i < jj; i++) lat += ((smp[i] >> kk) / 32) + 1;
      if (kk > 0) lat += jj;
      checkOutput($sformatf("latency j=%0d k=%0d", jj, kk), 32'(t1 - t0), 32'(lat));
    end
    tick();
  endtask

  task automatic doFlush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    modelFlush();
  endtask

  task automatic waitWords(input string tag);
    int n = 0;
    while (got_words.size() < exp_words.size() && n < 2000) begin
      @(negedge clk1);
      n++;
    end
    repeat (4) @(negedge clk1);
    checkOutput({tag, " word count"}, 32'(got_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++)
      checkOutput($sformatf("%s word[%0d]", tag, i),
                  (i < got_words.size()) ? got_words[i] : 32'hxxxxxxxx, exp_words[i]);
    tick();
  endtask

  task automatic clearWords();
    got_words.delete();
    exp_words.delete();
    model_bits.delete();
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.j = 6'd0;
    bus.k = 6'd0;
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.flush = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    reset = 1'b0;
    @(negedge clk1);
    checkOutput("reset word_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("reset word_out", bus.word_out, 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset sample_ready", 32'(bus.sample_ready), 32'd0);
    checkOutput("reset block_done", 32'(bus.block_done), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    tick();

    $display("[TB] basic block");
    smp[0] = 5; smp[1] = 0; smp[2] = 9; smp[3] = 3;
    done_count = 0;
    applyStimulus(4, 2, 1'b0, 1'b1);
    doFlush();
    waitWords("basic");
    checkOutput("basic literal word", (got_words.size() > 0) ? got_words[0] : 32'hxxxxxxxx, 32'h3668E000);
    checkOutput("basic block_done count", 32'(done_count), 32'd1);
    clearWords();

    // Flush with nothing accumulated must not produce a word.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk1);
      if (bus.word_valid || bus.busy) seen = 1'b1;
    end
    checkOutput("empty flush idle", 32'(seen), 32'd0);
    tick();

    $display("[TB] long FS run");
    smp[0] = 40;
    applyStimulus(1, 0, 1'b0, 1'b1);
    doFlush();
    waitWords("longfs");
    checkOutput("longfs literal word0", (got_words.size() > 0) ? got_words[0] : 32'hxxxxxxxx, 32'h10000000);
    checkOutput("longfs literal word1", (got_words.size() > 1) ? got_words[1] : 32'hxxxxxxxx, 32'h00080000);
    clearWords();

    $display("[TB] parameter errors");
    foreach (smp[i]) smp[i] = 0;
    pulseStart(0, 2, 1'b0);
    tick();
    checkOutput("err is a pulse j=0", 32'(bus.err), 32'd0);
    pulseStart(1, 15, 1'b0);
    tick();
    checkOutput("err is a pulse k=15", 32'(bus.err), 32'd0);
    pulseStart(33, 0, 1'b0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk1);
      if (bus.sample_ready || bus.busy) seen = 1'b1;
    end
    checkOutput("no load after rejected start", 32'(seen), 32'd0);
    tick();

    $display("[TB] block concatenation");
    smp[0] = 1; smp[1] = 2;
    applyStimulus(2, 1, 1'b0, 1'b1);
    applyStimulus(2, 1, 1'b0, 1'b1);
    doFlush();
    waitWords("concat");
    clearWords();

    $display("[TB] back-pressure");
    bp_mode = 1'b1;
    hold_check = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < JMAX; i++) smp[i] = int'($urandom_range(0, 255));
      applyStimulus(32, 3, 1'b1, 1'b0);
    end
    doFlush();
    waitWords("backpressure");
    bp_mode = 1'b0;
    hold_check = 1'b0;
    clearWords();
    tick();

    $display("[TB] reset mid-operation");
    smp[0] = 15; smp[1] = 0;
    pulseStart(2, 0, 1'b1);
    feedSamples(2, 1'b0);
    tick();
    tick();
    checkOutput("pre-reset fill", 32'(dut.fill), 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("post-reset busy", 32'(bus.busy), 32'd0);
    checkOutput("post-reset word_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("post-reset fill", 32'(dut.fill), 32'd0);
    clearWords();
    tick();
    smp[0] = 5; smp[1] = 0; smp[2] = 9; smp[3] = 3;
    applyStimulus(4, 2, 1'b0, 1'b1);
    doFlush();
    waitWords("after reset");
    checkOutput("after reset literal word", (got_words.size() > 0) ? got_words[0] : 32'hxxxxxxxx, 32'h3668E000);
    clearWords();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
